axi_wr_slave: RTL
=================

// Module: axi_wr_slave
// PURPOSE
// AXI4 write-channel responder at the slave end of the write mux. It takes one AW/W/B write
// transaction at a time and computes beat addresses for FIXED/INCR/WRAP bursts. Accepted beats go
// to a word-addressed SRAM write port with byte strobes, and the block returns a B response.
// Sits behind the master-side write mux, on the s_* / m_* general channel.
// PARAMETERS
// ID_W       4           AWID/BID width
// BASE_ADDR  32'h0000_0000 byte address of word 0 of the attached memory
// MEM_WORDS  1024        memory depth in 32-bit words (power of 2); AW = $clog2(MEM_WORDS)
// PORTS
// aclk            in   1     clock, all logic on rising edge
// aresetn         in   1     asynchronous active-low reset
// s_axi_awid      in   ID_W  write ID
// s_axi_awaddr    in   32    start byte address
// s_axi_awlen     in   8     beats-1
// s_axi_awsize    in   3     log2 bytes/beat
// s_axi_awburst   in   2     00 FIXED, 01 INCR, 10 WRAP, 11 reserved
// s_axi_awvalid   in   1     / s_axi_awready out 1: AW handshake
// s_axi_wdata     in   32    / s_axi_wstrb in 4 / s_axi_wlast in 1: write beat
// s_axi_wvalid    in   1     / s_axi_wready out 1: W handshake
// s_axi_bid       out  ID_W  / s_axi_bresp out 2: response
// s_axi_bvalid    out  1     / s_axi_bready in 1: B handshake
// mem_we          out  1     one-cycle write strobe
// mem_addr        out  AW    word index (beat_addr-BASE_ADDR)>>2
// mem_wdata       out  32    / mem_wstrb out 4: registered copy of beat data/strobes
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE. Reset mid-burst abandons the transaction; no B is issued.
// - FSM IDLE: awready=1, wready=0. On awvalid&awready, latch id/addr/len/size/burst, beat_cnt=0,
//   err flags cleared, go to DATA. W beats presented in IDLE stall (wready=0).
// - FSM DATA: awready=0, wready=1. Per accepted beat (wvalid&wready):
//   * Writes only if in range (BASE_ADDR<=addr<BASE_ADDR+4*MEM_WORDS) and no protocol error latched.
//     Then next cycle: mem_we=1 for 1 cycle, with mem_addr/mem_wdata/mem_wstrb registered.
//     mem_wstrb is wstrb unmodified.
//   * Out-of-range beat sets dec_err and is not written.
//   * Address update: FIXED unchanged. INCR addr+=(1<<size).
//     WRAP addr=(addr&~(W-1))|((addr+(1<<size))&(W-1)), with W=(len+1)<<size.
//   * beat_cnt+=1 (8-bit, saturates at 255).
//   * wlast=1 ends the burst and goes to RESP.
//   * wlast with beat_cnt!=len, or beat_cnt>len without wlast, sets slv_err.
//     Extra beats are accepted and not written.
// - Protocol errors latched at AW: burst=11, size>2, WRAP with len not in {1,3,7,15},
//   WRAP start not aligned to 1<<size. Each sets slv_err; the whole burst is drained, none written.
// - RESP: bvalid=1, bid=latched id, bresp=2'b10 SLVERR if slv_err, else 2'b11 DECERR if dec_err,
//   else 2'b00. bid/bresp stable while bvalid&!bready. On bready, bvalid=0 and go to IDLE.
//   awready=1 on the following cycle (minimum 1 idle cycle between transactions).
// - One outstanding transaction only; no interleaving; bid always equals the accepted awid.
// - Latency: AW accept->wready 1 cycle. Beat accept->mem_we 1 cycle.
//   wlast accept->bvalid 1 cycle.
// TESTING
// 1 INCR awaddr=0x10 len=3 size=2 id=5, 4 beats wstrb=F -> mem_we at words 4,5,6,7; B id=5 resp=00
// 2 WRAP awaddr=0x38 len=3 size=2 -> words 14,15,12,13; resp=00
// 3 FIXED awaddr=0x20 len=2, wstrb 1,2,4 -> word 8 written 3x with those strobes; resp=00
// 4 INCR len=3 with wlast on beat 2 -> 2 writes, B resp=10. Then len=1 with wlast never on
//   beat 2, beat 3 last -> 2 writes, resp=10
// 5 awaddr=BASE+4*MEM_WORDS-4 INCR len=1 -> 1st beat written, 2nd not; resp=11
//   awburst=11 -> 0 writes, resp=10
// 6 bready held low 5 cycles -> bvalid/bid stable, awready=0. aresetn low mid-burst -> outputs 0,
//   no B, next AW accepted normally

Source files
------------

// File: rtl/axi_wr_if.sv
// AXI4 write-channel bundle (AW, W and B) shared by a write master and its slave.
interface axi_wr_if #(
   parameter int ID_W = 4
);
   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awvalid;
   logic            awready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;
   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI4 write responder: walks FIXED/INCR/WRAP beat addresses,
// writes in-range beats to a word-addressed SRAM port and returns one B response per burst.
module axi_wr_slave #(
   parameter int          ID_W      = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_WORDS = 1024,
   localparam int         AW        = $clog2(MEM_WORDS)
) (
   input  logic          aclk,
   input  logic          aresetn,
   axi_wr_if.slave       s_axi,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wstrb
);
   localparam logic [31:0] MEM_BYTES   = 32'(4 * MEM_WORDS);
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [1:0]  BURST_WRAP  = 2'b10;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_r;
   logic            awready_r;
   logic            wready_r;
   logic            bvalid_r;
   logic [ID_W-1:0] bid_r;
   logic [1:0]      bresp_r;
   logic            mem_we_r;
   logic [AW-1:0]   mem_addr_r;
   logic [31:0]     mem_wdata_r;
   logic [3:0]      mem_wstrb_r;
   logic [ID_W-1:0] id_r;
   logic [31:0]     addr_r;
   logic [7:0]      len_r;
   logic [2:0]      size_r;
   logic [1:0]      burst_r;
   logic [7:0]      beat_cnt_r;
   logic            prot_err_r;
   logic            slv_err_r;
   logic            dec_err_r;

   logic            beat_fire_s;
   logic [32:0]     diff_s;
   logic            in_range_s;
   logic [31:0]     step_s;
   logic [31:0]     wrap_mask_s;
   logic [31:0]     next_addr_s;
   logic            write_ok_s;
   logic            cnt_err_s;
   logic [1:0]      resp_s;
   logic            aw_err_s;

   // Burst descriptors that can never be honoured; such bursts are drained without writes.
   function automatic logic aw_prot_err(input logic [1:0]  burst,
                                        input logic [2:0]  size,
                                        input logic [7:0]  len,
                                        input logic [31:0] addr);
      logic [31:0] align_mask;
      logic        wrap_len_ok;
      align_mask  = (32'd1 << size) - 32'd1;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      aw_prot_err = (burst == 2'b11) || (size > 3'd2) ||
                    ((burst == BURST_WRAP) && (!wrap_len_ok || ((addr & align_mask) != 32'd0)));
   endfunction

   // Per-beat decode: range check, next beat address, count errors and the response code.
   always_comb begin
      aw_err_s    = aw_prot_err(s_axi.awburst, s_axi.awsize, s_axi.awlen, s_axi.awaddr);
      beat_fire_s = s_axi.wvalid && wready_r;
      diff_s      = {1'b0, addr_r} - {1'b0, BASE_ADDR};
      in_range_s  = !diff_s[32] && (diff_s[31:0] < MEM_BYTES);
      step_s      = 32'd1 << size_r;
      wrap_mask_s = (({24'd0, len_r} + 32'd1) << size_r) - 32'd1;
      case (burst_r)
         BURST_FIXED: next_addr_s = addr_r;
         BURST_INCR:  next_addr_s = addr_r + step_s;
         BURST_WRAP:  next_addr_s = (addr_r & ~wrap_mask_s) | ((addr_r + step_s) & wrap_mask_s);
         default:     next_addr_s = addr_r;
      endcase
      write_ok_s = in_range_s && !prot_err_r && (beat_cnt_r <= len_r);
      if (s_axi.wlast) begin
         cnt_err_s = (beat_cnt_r != len_r);
      end else begin
         cnt_err_s = (beat_cnt_r > len_r);
      end
      // The closing beat's own errors must reach the response issued on the same edge.
      if (prot_err_r || slv_err_r || cnt_err_s) begin
         resp_s = RESP_SLVERR;
      end else if (dec_err_r || !in_range_s) begin
         resp_s = RESP_DECERR;
      end else begin
         resp_s = RESP_OKAY;
      end
   end

   // Transaction FSM with registered handshake, response and memory-port outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r     <= ST_IDLE;
         awready_r   <= 1'b0;
         wready_r    <= 1'b0;
         bvalid_r    <= 1'b0;
         bid_r       <= '0;
         bresp_r     <= 2'b00;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'd0;
         mem_wstrb_r <= 4'd0;
         id_r        <= '0;
         addr_r      <= 32'd0;
         len_r       <= 8'd0;
         size_r      <= 3'd0;
         burst_r     <= 2'b00;
         beat_cnt_r  <= 8'd0;
         prot_err_r  <= 1'b0;
         slv_err_r   <= 1'b0;
         dec_err_r   <= 1'b0;
      end else begin
         mem_we_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               wready_r <= 1'b0;
               bvalid_r <= 1'b0;
               if (s_axi.awvalid && awready_r) begin
                  id_r       <= s_axi.awid;
                  addr_r     <= s_axi.awaddr;
                  len_r      <= s_axi.awlen;
                  size_r     <= s_axi.awsize;
                  burst_r    <= s_axi.awburst;
                  beat_cnt_r <= 8'd0;
                  prot_err_r <= aw_err_s;
                  slv_err_r  <= aw_err_s;
                  dec_err_r  <= 1'b0;
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b1;
                  state_r    <= ST_DATA;
               end else begin
                  awready_r <= 1'b1;
               end
            end
            ST_DATA: begin
               if (beat_fire_s) begin
                  if (write_ok_s) begin
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= diff_s[AW+1:2];
                     mem_wdata_r <= s_axi.wdata;
                     mem_wstrb_r <= s_axi.wstrb;
                  end
                  addr_r <= next_addr_s;
                  if (beat_cnt_r != 8'hFF) begin
                     beat_cnt_r <= beat_cnt_r + 8'd1;
                  end
                  if (cnt_err_s) begin
                     slv_err_r <= 1'b1;
                  end
                  if (!in_range_s) begin
                     dec_err_r <= 1'b1;
                  end
                  if (s_axi.wlast) begin
                     wready_r <= 1'b0;
                     bvalid_r <= 1'b1;
                     bid_r    <= id_r;
                     bresp_r  <= resp_s;
                     state_r  <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (s_axi.bready && bvalid_r) begin
                  bvalid_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_axi.awready = awready_r;
   assign s_axi.wready  = wready_r;
   assign s_axi.bvalid  = bvalid_r;
   assign s_axi.bid     = bid_r;
   assign s_axi.bresp   = bresp_r;
   assign mem_we        = mem_we_r;
   assign mem_addr      = mem_addr_r;
   assign mem_wdata     = mem_wdata_r;
   assign mem_wstrb     = mem_wstrb_r;
endmodule
